ram8_bank: RTL and testbench
============================

// Module: ram8_bank
// PURPOSE
//  - Eight-word HACK data store: the stage directly downstream of the 1-to-2 load demux.
//  - A demux tree routes a single load strobe to one word; a mux tree returns the addressed word.
//  - Building block for RAM64 and up; also serves as the CPU's small scratch register file.
// PARAMETERS
//  - WIDTH   16  data word width, bits
//  - ADDR_W  3   address width; DEPTH = 2**ADDR_W words (8 at default)
// PORTS
//  - clk      in   1       system clock; all state updates on rising edge
//  - rst      in   1       synchronous, active-high reset
//  - in       in   WIDTH   write data
//  - address  in   ADDR_W  word select for both write and read
//  - load     in   1       write strobe, sampled at rising edge of clk
//  - out      out  WIDTH   read data = word[address] (see BEHAVIOUR)
//  - load_oh  out  DEPTH   one-hot decoded load enables (demux tree output), debug/cascade
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous and active-high.
//  - Storage: DEPTH registers of WIDTH bits. Reset value of every word is 0.
//  - Reset has priority: rst=1 at an edge clears all words, even if load=1.
//  - Decode: load_oh[i] = load & (address == i). Built as a binary tree of 1-to-2 demux stages.
//    - Purely combinational.
//    - Exactly one bit is high when load=1; all bits are zero when load=0.
//    - load_oh does not depend on rst.
//  - Write:
//    - At a rising edge with rst=0 and load_oh[i]=1, word[i] <= in.
//    - All other words hold.
//    - Write latency is 1 cycle.
//  - Read:
//    - out = word[address], combinational from address; 0-cycle latency, no read enable.
//    - After reset, out = 0 for every address.
//  - Same-address read during write (load=1, address=A): see CONFIGURATION.
//  - Writes on consecutive cycles to different addresses each complete independently.
//  - Back-to-back writes to the same address: the last value wins.
//  - Address range is always exact (2**ADDR_W words), so no out-of-range case exists.
//  - X/Z on address while load=0 must not corrupt stored words.
//  - Reset mid-sequence: every write committed before the reset edge is discarded.
//    - A write presented in the reset cycle is dropped.
//    - The first edge after rst falls accepts writes normally.
// CONFIGURATION
//  - RAM8_WRITE_THROUGH_EN
//    - Defined: when load=1 and rst=0, out = in for the addressed word in the same cycle (bypass).
//    - Not defined: out shows the old word[address] until the edge. This is HACK semantics.
//    - Stored state is identical in both builds; only the combinational out path differs.
// TESTING
//  - Reset: write 0xFFFF to all 8 words, assert rst for 1 edge
//    -> out = 0x0000 at addresses 0..7; load_oh = 0 while load=0.
//  - Fill/readback: write word i = 0x1000+i for i = 0..7, one per cycle, then read 0..7
//    -> out = 0x1000..0x1007; load_oh one-hot 0x01..0x80 during the writes.
//  - Hold: load=0, in=0xBEEF, sweep address for 16 cycles -> contents unchanged.
//  - Read during write: address=3 holds 0x1003; load=1, in=0xAAAA
//    - Before the edge, without the macro: out = 0x1003.
//    - Before the edge, with the macro: out = 0xAAAA.
//    - After the edge, both builds: out = 0xAAAA.
//  - Reset priority: rst=1, load=1, address=5, in=0x5555 -> after the edge, word5 = 0x0000.
//  - Reset mid-sequence: write addresses 0..3, rst on the edge where address 4 is written, release rst, write address 6 = 0x0606
//    -> words 0..5 and 7 = 0; word6 = 0x0606.

Source files
------------

// File: rtl/ram8_bank.sv
// ram8_bank: eight-word HACK data store. A 1-to-2 demux tree steers the load strobe; a mux tree returns word[address].
// Optional build macro RAM8_WRITE_THROUGH_EN bypasses write data onto out during a write cycle.
module ram8_bank #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in,
    input  logic [ADDR_W-1:0]      address,
    input  logic                   load,
    output logic [WIDTH-1:0]       out,
    output logic [(2**ADDR_W)-1:0] load_oh
);
    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] w_rd;

    // Demux tree: stage l splits on address bit ADDR_W-1-l, so leaf index equals the address.
    for (genvar l = 0; l < ADDR_W; l++) begin : g_dmx
        localparam int unsigned N = 2**l;
        logic [N-1:0]   w_src;
        logic [2*N-1:0] w_node;
        if (l == 0) begin : g_root
            assign w_src = load;
        end else begin : g_inner
            assign w_src = g_dmx[l-1].w_node;
        end
        for (genvar k = 0; k < N; k++) begin : g_stage
            assign w_node[2*k]   = w_src[k] & ~address[ADDR_W-1-l];
            assign w_node[2*k+1] = w_src[k] &  address[ADDR_W-1-l];
        end
    end

    assign load_oh = g_dmx[ADDR_W-1].w_node;

    // Mux tree: stage m selects on address bit m, reducing the word set by half each stage.
    for (genvar m = 0; m < ADDR_W; m++) begin : g_mux
        localparam int unsigned N = 2**(ADDR_W-1-m);
        logic [WIDTH-1:0] w_word [N];
        for (genvar k = 0; k < N; k++) begin : g_node
            if (m == 0) begin : g_leaf
                assign w_word[k] = address[0] ? r_mem[2*k+1] : r_mem[2*k];
            end else begin : g_up
                assign w_word[k] = address[m] ? g_mux[m-1].w_word[2*k+1]
                                              : g_mux[m-1].w_word[2*k];
            end
        end
    end

    assign w_rd = g_mux[ADDR_W-1].w_word[0];

    // Reset clears every word and overrides any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (load_oh[i]) begin
                    r_mem[i] <= in;
                end
            end
        end
    end

`ifdef RAM8_WRITE_THROUGH_EN
    assign out = (load && !rst) ? in : w_rd;
`else
    assign out = w_rd;
`endif

endmodule

// File: tb/tb_ram8_bank.sv
// Self-checking bench for ram8_bank: scoreboard of expected out/load_oh, one task per scenario.
module tb_ram8_bank;
    typedef struct packed {
        logic [15:0] out;
        logic [7:0]  oh;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic [2:0]  address;
    logic        load;
    logic [15:0] out;
    logic [7:0]  load_oh;

    exp_t sb[$];
    exp_t e;
    int   n_vec;
    int   n_err;

    ram8_bank #(.WIDTH(16), .ADDR_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .address (address),
        .load    (load),
        .out     (out),
        .load_oh (load_oh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value visible on out before the edge of a write cycle.
    function automatic logic [15:0] rdw_exp(input logic [15:0] old_v, input logic [15:0] new_v);
`ifdef RAM8_WRITE_THROUGH_EN
        return new_v;
`else
        return old_v;
`endif
    endfunction

    // Drive one cycle at the falling edge and queue what out/load_oh must show before the next rising edge.
    task automatic apply(input logic r, input logic l, input logic [2:0] a,
                         input logic [15:0] d, input logic [15:0] exp_out, input bit chk);
        exp_t x;
        @(negedge clk);
        rst     = r;
        load    = l;
        address = a;
        in      = d;
        x.out   = exp_out;
        x.oh    = l ? (8'h01 << a) : 8'h00;
        if (chk) sb.push_back(x);
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        apply(1'b0, 1'b0, 3'd0, 16'h0, 16'h0000, 1'b1);
        #1; e = sb.pop_front(); n_vec++;
        if (out !== e.out || load_oh !== e.oh) begin
            n_err++; $display("FAIL reset_init out=%h oh=%h want out=%h oh=%h", out, load_oh, e.out, e.oh);
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 3'(i), 16'hFFFF, rdw_exp(16'h0000, 16'hFFFF), 1'b1);
            #1; e = sb.pop_front(); n_vec++;
            if (out !== e.out || load_oh !== e.oh) begin
                n_err++; $display("FAIL reset_fill[%0d] out=%h oh=%h want out=%h oh=%h", i, out, load_oh, e.out, e.oh);
            end
        end
        apply(1'b1, 1'b0, 3'd0, 16'h0, 16'hFFFF, 1'b1);
        #1; e = sb.pop_front(); n_vec++;
        if (out !== e.out || load_oh !== e.oh) begin
            n_err++; $display("FAIL reset_pre out=%h oh=%h want out=%h oh=%h", out, load_oh, e.out, e.oh);
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 3'(i), 16'h0, 16'h0000, 1'b1);
            #1; e = sb.pop_front(); n_vec++;
            if (out !== e.out || load_oh !== e.oh) begin
                n_err++; $display("FAIL reset_read[%0d] out=%h oh=%h want out=%h oh=%h", i, out, load_oh, e.out, e.oh);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 3'(i), 16'h1000 + 16'(i), rdw_exp(16'h0000, 16'h1000 + 16'(i)), 1'b1);
            #1; e = sb.pop_front(); n_vec++;
            if (out !== e.out || load_oh !== e.oh) begin
                n_err++; $display("FAIL fill_wr[%0d] out=%h oh=%h want out=%h oh=%h", i, out, load_oh, e.out, e.oh);
            end
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 3'(i), 16'h0, 16'h1000 + 16'(i), 1'b1);
            #1; e = sb.pop_front(); n_vec++;
            if (out !== e.out || load_oh !== e.oh) begin
                n_err++; $display("FAIL fill_rd[%0d] out=%h oh=%h want out=%h oh=%h", i, out, load_oh, e.out, e.oh);
            end
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 16; c++) begin
            if (c == 5) begin
                apply(1'b0, 1'b0, 3'bxxx, 16'hBEEF, 16'h0, 1'b0);
            end else begin
                apply(1'b0, 1'b0, 3'(7 - (c % 8)), 16'hBEEF, 16'h1000 + 16'(7 - (c % 8)), 1'b1);
                #1; e = sb.pop_front(); n_vec++;
                if (out !== e.out || load_oh !== e.oh) begin
                    n_err++; $display("FAIL hold[%0d] out=%h oh=%h want out=%h oh=%h", c, out, load_oh, e.out, e.oh);
                end
            end
        end
    endtask

    task automatic test_read_during_write();
        apply(1'b0, 1'b1, 3'd3, 16'hAAAA, rdw_exp(16'h1003, 16'hAAAA), 1'b1);
        #1; e = sb.pop_front(); n_vec++;
        if (out !== e.out || load_oh !== e.oh) begin
            n_err++; $display("FAIL rdw_pre out=%h oh=%h want out=%h oh=%h", out, load_oh, e.out, e.oh);
        end
        apply(1'b0, 1'b0, 3'd3, 16'h0, 16'hAAAA, 1'b1);
        #1; e = sb.pop_front(); n_vec++;
        if (out !== e.out || load_oh !== e.oh) begin
            n_err++; $display("FAIL rdw_post out=%h oh=%h want out=%h oh=%h", out, load_oh, e.out, e.oh);
        end
    endtask

    task automatic test_back_to_back();
        apply(1'b0, 1'b1, 3'd2, 16'h1111, rdw_exp(16'h1002, 16'h1111), 1'b1);
        #1; e = sb.pop_front(); n_vec++;
        if (out !== e.out || load_oh !== e.oh) begin
            n_err++; $display("FAIL b2b_wr1 out=%h oh=%h want out=%h oh=%h", out, load_oh, e.out, e.oh);
        end
        apply(1'b0, 1'b1, 3'd2, 16'h2222, rdw_exp(16'h1111, 16'h2222), 1'b1);
        #1; e = sb.pop_front(); n_vec++;
        if (out !== e.out || load_oh !== e.oh) begin
            n_err++; $display("FAIL b2b_wr2 out=%h oh=%h want out=%h oh=%h", out, load_oh, e.out, e.oh);
        end
        apply(1'b0, 1'b0, 3'd2, 16'h0, 16'h2222, 1'b1);
        #1; e = sb.pop_front(); n_vec++;
        if (out !== e.out || load_oh !== e.oh) begin
            n_err++; $display("FAIL b2b_rd out=%h oh=%h want out=%h oh=%h", out, load_oh, e.out, e.oh);
        end
    endtask

    task automatic test_reset_priority();
        // Write-through is suppressed while rst is high, so both builds show the stored word.
        apply(1'b1, 1'b1, 3'd5, 16'h5555, 16'h1005, 1'b1);
        #1; e = sb.pop_front(); n_vec++;
        if (out !== e.out || load_oh !== e.oh) begin
            n_err++; $display("FAIL rstpri_pre out=%h oh=%h want out=%h oh=%h", out, load_oh, e.out, e.oh);
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 3'(i), 16'h5555, 16'h0000, 1'b1);
            #1; e = sb.pop_front(); n_vec++;
            if (out !== e.out || load_oh !== e.oh) begin
                n_err++; $display("FAIL rstpri_rd[%0d] out=%h oh=%h want out=%h oh=%h", i, out, load_oh, e.out, e.oh);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 3'(i), 16'h0A00 + 16'(i), rdw_exp(16'h0000, 16'h0A00 + 16'(i)), 1'b1);
            #1; e = sb.pop_front(); n_vec++;
            if (out !== e.out || load_oh !== e.oh) begin
                n_err++; $display("FAIL rstmid_wr[%0d] out=%h oh=%h want out=%h oh=%h", i, out, load_oh, e.out, e.oh);
            end
        end
        apply(1'b1, 1'b1, 3'd4, 16'h0A04, 16'h0000, 1'b1);
        #1; e = sb.pop_front(); n_vec++;
        if (out !== e.out || load_oh !== e.oh) begin
            n_err++; $display("FAIL rstmid_rst out=%h oh=%h want out=%h oh=%h", out, load_oh, e.out, e.oh);
        end
        apply(1'b0, 1'b1, 3'd6, 16'h0606, rdw_exp(16'h0000, 16'h0606), 1'b1);
        #1; e = sb.pop_front(); n_vec++;
        if (out !== e.out || load_oh !== e.oh) begin
            n_err++; $display("FAIL rstmid_wr6 out=%h oh=%h want out=%h oh=%h", out, load_oh, e.out, e.oh);
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 3'(i), 16'h0, (i == 6) ? 16'h0606 : 16'h0000, 1'b1);
            #1; e = sb.pop_front(); n_vec++;
            if (out !== e.out || load_oh !== e.oh) begin
                n_err++; $display("FAIL rstmid_rd[%0d] out=%h oh=%h want out=%h oh=%h", i, out, load_oh, e.out, e.oh);
            end
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        load    = 1'b0;
        address = 3'd0;
        in      = 16'h0;
        test_reset();
        test_fill();
        test_hold();
        test_read_during_write();
        test_back_to_back();
        test_reset_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
